// File: rtl/chroma_downsample.sv
// 4:2:0 chroma subsampler: Y blocks pass through, four Cb/Cr 8x8 quadrants average into one 8x8 block.
// Optional build macro CHROMA_DS_ERR_CNT_EN adds a saturating sequence-error counter output (err_cnt).
module chroma_downsample #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned CH_W   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  valid_in,
  output logic                                  ready_out,
  input  logic [CH_W-1:0]                       ch_in,
  input  logic signed [7:0][7:0][DATA_W-1:0]    block_in,
  output logic                                  valid_out,
  input  logic                                  ready_in,
  output logic [CH_W-1:0]                       ch_out,
  output logic signed [7:0][7:0][DATA_W-1:0]    block_out,
  output logic                                  seq_err
`ifdef CHROMA_DS_ERR_CNT_EN
  ,
  output logic [7:0]                            err_cnt
`endif
);

  localparam int unsigned SW = DATA_W + 2;
  localparam logic [CH_W-1:0] CH_Y  = CH_W'(0);
  localparam logic [CH_W-1:0] CH_CB = CH_W'(1);
  localparam logic [CH_W-1:0] CH_CR = CH_W'(2);

  logic [1:0]      quad_q, quad_nxt;
  logic [CH_W-1:0] grp_q, grp_nxt;

  logic accept, is_y, is_c, restart;
  logic wr_en, load_y, load_c, err_evt;
  logic [1:0] wr_q;

  logic [3:0][3:0][DATA_W-1:0] avg;
  logic signed [SW-1:0]        s;
  logic [7:0][7:0][DATA_W-1:0] acc_buf, merged;

  assign ready_out = !valid_out || ready_in;
  assign accept    = valid_in && ready_out;
  assign is_y      = (ch_in == CH_Y);
  assign is_c      = (ch_in == CH_CB) || (ch_in == CH_CR);
  // A chroma beat opens a new group when idle or when its channel breaks the current group.
  assign restart   = (quad_q == 2'd0) || (ch_in != grp_q);

  // Rounded 2x2 averages of the incoming block, (sum + 2) >>> 2.
  always_comb begin
    avg = '0;
    s   = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = SW'($signed(block_in[2*i][2*j]))   + SW'($signed(block_in[2*i][2*j+1]))
          + SW'($signed(block_in[2*i+1][2*j])) + SW'($signed(block_in[2*i+1][2*j+1]))
          + SW'(2);
        avg[i][j] = DATA_W'(s >>> 2);
      end
    end
  end

  // Accumulator buffer with the current quadrant overlaid, so quadrant 3 can be emitted the same cycle.
  always_comb begin
    merged = acc_buf;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if ((r / 4) == int'(wr_q[1]) && (c / 4) == int'(wr_q[0])) begin
          merged[r][c] = avg[r % 4][c % 4];
        end
      end
    end
  end

  // Group state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quad_q <= 2'd0;
      grp_q  <= '0;
    end else begin
      quad_q <= quad_nxt;
      grp_q  <= grp_nxt;
    end
  end

  // Group next-state.
  always_comb begin
    quad_nxt = quad_q;
    grp_nxt  = grp_q;
    if (accept) begin
      if (is_y) begin
        quad_nxt = 2'd0;
      end else if (is_c) begin
        if (restart) begin
          grp_nxt  = ch_in;
          quad_nxt = 2'd1;
        end else begin
          quad_nxt = quad_q + 2'd1;
        end
      end
    end
  end

  // Group outputs: buffer write, output loads, sequence-error events.
  always_comb begin
    wr_en   = accept && is_c;
    wr_q    = restart ? 2'd0 : quad_q;
    load_y  = accept && is_y;
    load_c  = accept && is_c && !restart && (quad_q == 2'd3);
    err_evt = accept && (!(is_y || is_c) || ((quad_q != 2'd0) && (is_y || ch_in != grp_q)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_buf <= '0;
    end else if (wr_en) begin
      acc_buf <= merged;
    end
  end

  // Output register holds its payload until the downstream handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      ch_out    <= '0;
      block_out <= '0;
    end else if (load_y) begin
      valid_out <= 1'b1;
      ch_out    <= CH_Y;
      block_out <= block_in;
    end else if (load_c) begin
      valid_out <= 1'b1;
      ch_out    <= grp_q;
      block_out <= merged;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_err <= 1'b0;
    end else if (err_evt) begin
      seq_err <= 1'b1;
    end
  end

`ifdef CHROMA_DS_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err_evt && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
